// File: rtl/fft_frame_assembler.sv
// Streams samples into a packed FFT frame with a one-frame output register.
// Define FFT_FRAME_OVERLAP_EN to keep the upper half of each frame for the next.
module fft_frame_assembler #(
  parameter int sample_size = 32,
  parameter int buffer_size = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic signed [sample_size-1:0]        s_data,
  input  logic                                 flush,
  output logic                                 frame_valid,
  input  logic                                 frame_ready,
  output logic signed [buffer_size*sample_size-1:0] frame_data
);

  localparam int iw   = $clog2(buffer_size);
  localparam int half = buffer_size / 2;

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  typedef logic [buffer_size-1:0][sample_size-1:0] buf_t;

  state_t  state_q, state_d;
  logic [iw-1:0] widx_q, widx_d;
  buf_t    fill_q, fill_d, frame_nx;
  logic [buffer_size*sample_size-1:0] out_q, out_d;
  logic    fv_q, fv_d;
  logic    accept, last, out_free, xfer;

  always_comb begin
    s_ready  = (state_q == FILL);
    accept   = s_valid & s_ready;
    out_free = ~fv_q | frame_ready;
    last     = accept & (widx_q == iw'(buffer_size - 1));
    frame_nx = fill_q;
    if (accept) frame_nx[widx_q] = s_data;
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    fill_d  = fill_q;
    xfer    = 1'b0;
    if (flush) begin
      state_d = FILL;
      widx_d  = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          fill_d = frame_nx;
          if (accept) begin
            if (!last) widx_d = widx_q + 1'b1;
            else if (out_free) xfer = 1'b1;
            else state_d = FULL;
          end
        end
        FULL: begin
          if (out_free) begin
            xfer    = 1'b1;
            state_d = FILL;
          end
        end
      endcase
    end
    if (xfer) begin
`ifdef FFT_FRAME_OVERLAP_EN
      // newest half becomes the oldest half of the next frame
      for (int i = 0; i < half; i++) fill_d[i] = frame_nx[i+half];
      widx_d = iw'(half);
`else
      widx_d = '0;
`endif
    end
  end

  always_comb begin
    out_d = xfer ? frame_nx : out_q;
    fv_d  = xfer | (fv_q & ~frame_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      widx_q  <= '0;
      fill_q  <= '0;
      out_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      fv_q    <= fv_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame_data  = out_q;

endmodule

// File: tb/tb_fft_frame_assembler.sv
// Bench for fft_frame_assembler: directed scenarios plus random traffic
// compared against a queue-based frame model.
module tb_fft_frame_assembler;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sv, fl, fr;
  logic [W-1:0] sd;
  logic s_ready, frame_valid;
  logic [N*W-1:0] fd;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] cur[$];
  logic m_fv;
  logic [N*W-1:0] m_fd;

  always #5 clk = ~clk;

  fft_frame_assembler #(
    .sample_size(W),
    .buffer_size(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(sv),
    .s_ready(s_ready),
    .s_data(sd),
    .flush(fl),
    .frame_valid(frame_valid),
    .frame_ready(fr),
    .frame_data(fd)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_fv = 1'b0;
    m_fd = '0;
  endtask

  task automatic model_edge();
    bit free;
    free = !m_fv || fr;
    if (fl) begin
      cur.delete();
      if (fr) m_fv = 1'b0;
    end else begin
      if (sv && cur.size() < N) cur.push_back(sd);
      if (cur.size() == N && free) begin
        for (int i = 0; i < N; i++) m_fd[i*W +: W] = cur[i];
        m_fv = 1'b1;
`ifdef FFT_FRAME_OVERLAP_EN
        cur = cur[N/2:$];
`else
        cur.delete();
`endif
      end else if (fr) begin
        m_fv = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("s_ready", 64'(s_ready), 64'(cur.size() < N));
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("frame_data", 64'(fd), 64'(m_fd));
  endtask

  task automatic step(bit v, logic [W-1:0] d, bit f, bit r);
    sv = v;
    sd = d;
    fl = f;
    fr = r;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    rst_n = 1'b0;
    sv = 1'b0; sd = '0; fl = 1'b0; fr = 1'b0;
    model_reset();
    #12;
    chk("rst_fv", 64'(frame_valid), 64'd0);
    chk("rst_fd", 64'(fd), 64'd0);
    rst_n = 1'b1;

    // basic packing
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 1);
    chk("pack_fv", 64'(frame_valid), 64'd1);
    chk("pack_fd", 64'(fd), 64'h04030201);
    step(0, 0, 1, 1);
    chk("pack_clr", 64'(frame_valid), 64'd0);

    // backpressure
    for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 0);
    chk("bp_sready", 64'(s_ready), 64'd0);
    chk("bp_hold", 64'(fd), 64'h04030201);
    step(0, 0, 0, 1);
    chk("bp_fv", 64'(frame_valid), 64'd1);
`ifdef FFT_FRAME_OVERLAP_EN
    chk("bp_next", 64'(fd), 64'h06050403);
`else
    chk("bp_next", 64'(fd), 64'h08070605);
`endif
    chk("bp_sready2", 64'(s_ready), 64'd1);
    step(0, 0, 1, 1);

    // flush drops the partial frame and the colliding sample
    step(1, 9, 0, 1);
    step(1, 10, 0, 1);
    step(1, 11, 1, 1);
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 1);
    chk("fl_fd", 64'(fd), 64'h04030201);
    chk("fl_fv", 64'(frame_valid), 64'd1);
    step(0, 0, 1, 1);

    // reset mid-frame
    step(1, 5, 0, 0);
    step(1, 6, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr_fv", 64'(frame_valid), 64'd0);
    chk("mr_fd", 64'(fd), 64'd0);
    #10 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 1);
    chk("mr_fd2", 64'(fd), 64'h04030201);

    // overlap behaviour over six samples
    step(0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) step(1, W'(i), 0, 1);
`ifdef FFT_FRAME_OVERLAP_EN
    chk("ov_fv", 64'(frame_valid), 64'd1);
    chk("ov_fd", 64'(fd), 64'h06050403);
`else
    chk("ov_fv", 64'(frame_valid), 64'd0);
    chk("ov_fd", 64'(fd), 64'h04030201);
`endif
    step(0, 0, 1, 1);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 9) < 7,
           W'($urandom),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_assembler.md
FFT_FRAME_ASSEMBLER -- requirements
Module: fft_frame_assembler

Interface
REQ-001 SHALL have parameter sample_size, default 32: width of one signed time-domain sample.
REQ-002 SHALL have parameter buffer_size, default 32: samples per FFT frame; a power of two, at least 4.
REQ-003 SHALL use one clock, with reset asynchronous and active-low.
REQ-004 SHALL have port clk  input  1: rising-edge clock.
REQ-005 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-006 SHALL have port s_valid  input  1: s_data holds a sample.
REQ-007 SHALL have port s_ready  output  1: the block can accept a sample.
REQ-008 SHALL have port s_data  input  sample_size, signed: streamed time-domain sample.
REQ-009 SHALL have port flush  input  1: synchronous discard of the partially filled frame.
REQ-010 SHALL have port frame_valid  output  1: frame_data holds a complete frame.
REQ-011 SHALL have port frame_ready  input  1: the FFT consumer accepts the frame.
REQ-012 SHALL have port frame_data  output  buffer_size*sample_size, signed: packed frame, matching the FFT input_bitstream layout.

Function
REQ-013 SHALL accept a sample on a clk edge where s_valid and s_ready are both 1.
REQ-014 SHALL write the k-th accepted sample of a frame to fill-buffer slice [k*sample_size +: sample_size]; the first sample goes to slice 0.
REQ-015 SHALL keep a write index from 0 to buffer_size-1 and two states, FILL and FULL.
REQ-016 FILL: s_ready=1; when the sample landing at index buffer_size-1 is accepted, SHALL move the fill buffer into the output register if the output register is free; otherwise SHALL enter FULL.
REQ-017 Output register is free when frame_valid=0, or when frame_valid=1 and frame_ready=1 in the same cycle.
REQ-018 FULL: s_ready=0; SHALL move the fill buffer to the output register and return to FILL on the first cycle where the output register is free.
REQ-019 SHALL assert frame_valid the cycle after the transfer; latency from last sample accepted to frame_valid is 1 cycle when the output register is free.
REQ-020 SHALL hold frame_data and frame_valid stable while frame_valid=1 and frame_ready=0.
REQ-021 SHALL clear frame_valid the cycle after frame_valid and frame_ready are both 1, unless a new transfer occurs on that same edge, in which case frame_valid stays 1 with the new data.
REQ-022 SHALL reset the write index to 0 after a transfer (see REQ-032 for overlap).
REQ-023 flush=1: SHALL set the write index to 0 and the state to FILL, and SHALL leave the output register and frame_valid untouched.
REQ-024 If flush and an accepted sample fall on the same edge, flush wins and the sample is discarded.
REQ-025 Frames SHALL pass through the FFT pipeline in order, with no frame dropped or duplicated.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: state FILL, write index 0, frame_valid 0, frame_data 0, fill buffer 0.
REQ-027 s_ready SHALL read 1 from the first rising clk edge after rst_n deasserts.
REQ-028 A partial frame held when reset asserts SHALL be lost; no frame SHALL be emitted for it.

Configuration
REQ-029 SHALL be controlled by macro FFT_FRAME_OVERLAP_EN.
REQ-030 Without FFT_FRAME_OVERLAP_EN, each frame SHALL contain buffer_size fresh samples.
REQ-031 With FFT_FRAME_OVERLAP_EN, each frame SHALL overlap the previous one by 50%.
REQ-032 With FFT_FRAME_OVERLAP_EN, on each transfer the fill buffer's upper half SHALL move to its lower half and the write index SHALL restart at buffer_size/2, so each later frame needs buffer_size/2 new samples.
REQ-033 With FFT_FRAME_OVERLAP_EN, the first frame after reset or flush SHALL still need buffer_size samples.

Verification (bench uses buffer_size=4, sample_size=8)
REQ-034 Basic packing: feed 1,2,3,4 back to back with frame_ready=1 -> frame_valid high 1 cycle after sample 4; frame_data = 0x04030201.
REQ-035 Backpressure: hold frame_ready=0 and feed 8 samples, 1..8 -> s_ready falls after sample 8 is accepted; frame 0x04030201 is held stable; after one frame_ready pulse, the next frame is 0x08070605 and s_ready returns to 1.
REQ-036 Flush: feed 9,10, pulse flush while s_valid=1 with data 11, then feed 1,2,3,4 -> single frame 0x04030201; 9, 10 and 11 never appear.
REQ-037 Reset mid-frame: feed 5,6, assert rst_n=0 between clk edges -> frame_valid=0 and frame_data=0 immediately; after release, 1..4 gives 0x04030201.
REQ-038 Overlap, with FFT_FRAME_OVERLAP_EN: feed 1..6 -> frames 0x04030201 then 0x06050403.
REQ-039 Overlap, without FFT_FRAME_OVERLAP_EN: feed 1..6 -> one frame only, 0x04030201.
